// File: rtl/dcache_pkg.sv
// Shared constants, state encoding and word-select helper for the data cache controller.
package dcache_pkg;

    localparam int LINE_BITS      = 128;
    localparam int WORD_BITS      = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_BITS    = 2;

    // Field positions for the default 10-bit word address: [9:7] tag, [6:2] index, [1:0] offset.
    localparam int DEF_ADDR_SIZE  = 10;
    localparam int DEF_INDEX_BITS = 5;
    localparam int INDEX_LSB      = OFFSET_BITS;
    localparam int TAG_LSB        = OFFSET_BITS + DEF_INDEX_BITS;
    localparam int DEF_TAG_BITS   = DEF_ADDR_SIZE - DEF_INDEX_BITS - OFFSET_BITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_e;

    function automatic logic [WORD_BITS-1:0] word_sel(input logic [LINE_BITS-1:0] line,
                                                      input logic [OFFSET_BITS-1:0] off);
        return line[off*WORD_BITS +: WORD_BITS];
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU load/store port and main-memory port of the data cache, bundled with controller/environment views.
interface dcache_if
    import dcache_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDR_SIZE = 10
);
    logic                  cpu_read_en;
    logic                  cpu_write_en;
    logic [ADDR_SIZE-1:0]  cpu_address;
    logic [WIDTH-1:0]      cpu_data_in;
    logic [WIDTH-1:0]      cpu_data_out;
    logic                  stall;

    logic                  mem_read_en;
    logic                  mem_write_en;
    logic [ADDR_SIZE-1:0]  mem_address;
    logic [WIDTH-1:0]      mem_data_out;
    logic [LINE_BITS-1:0]  mem_data_in;
    logic                  mem_ready;

    // slave: the cache controller, serving CPU requests and issuing memory requests
    modport slave (
        input  cpu_read_en, cpu_write_en, cpu_address, cpu_data_in,
        output cpu_data_out, stall,
        output mem_read_en, mem_write_en, mem_address, mem_data_out,
        input  mem_data_in, mem_ready
    );

    // master: CPU plus main memory around the cache
    modport master (
        output cpu_read_en, cpu_write_en, cpu_address, cpu_data_in,
        input  cpu_data_out, stall,
        input  mem_read_en, mem_write_en, mem_address, mem_data_out,
        output mem_data_in, mem_ready
    );
endinterface

// File: rtl/dcache_line_store.sv
// Direct-mapped line storage: valid/tag/data arrays, combinational lookup, line fill and word update.
// Only valid bits are reset; tag and data are don't-care until their line is filled.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int TAG_BITS   = 3
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  i_rd_index,
    input  logic [TAG_BITS-1:0]    i_rd_tag,
    input  logic [OFFSET_BITS-1:0] i_rd_offset,
    output logic                   o_hit,
    output logic [WORD_BITS-1:0]   o_rd_word,
    input  logic                   i_fill_en,
    input  logic [INDEX_BITS-1:0]  i_fill_index,
    input  logic [TAG_BITS-1:0]    i_fill_tag,
    input  logic [LINE_BITS-1:0]   i_fill_data,
    input  logic                   i_upd_en,
    input  logic [INDEX_BITS-1:0]  i_upd_index,
    input  logic [OFFSET_BITS-1:0] i_upd_offset,
    input  logic [WORD_BITS-1:0]   i_upd_data
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]     r_valid;
    logic [TAG_BITS-1:0]  r_tag  [LINES];
    logic [LINE_BITS-1:0] r_data [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_fill_en) begin
            r_valid[i_fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[i_fill_index]  <= i_fill_tag;
            r_data[i_fill_index] <= i_fill_data;
        end else if (i_upd_en) begin
            r_data[i_upd_index][i_upd_offset*WORD_BITS +: WORD_BITS] <= i_upd_data;
        end
    end

    assign o_hit     = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
    assign o_rd_word = word_sel(r_data[i_rd_index], i_rd_offset);

endmodule

// File: rtl/dcache_ctrl.sv
// Write-through, no-write-allocate direct-mapped D-cache FSM; read hits answer in the request cycle.
// Misses and all stores stall the CPU until mem_ready. Optional hit/miss counters under DCACHE_STATS_EN.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_SIZE  = 10,
    parameter int INDEX_BITS = 5
)(
    input  logic         clk,
    input  logic         rst,
    dcache_if.slave      bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);
    localparam int TAG_BITS = ADDR_SIZE - INDEX_BITS - OFFSET_BITS;

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_REFILL = ST_REFILL;
    localparam logic [1:0] S_WRITE  = ST_WRITE;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [ADDR_SIZE-1:0] r_req_addr;
    logic [WIDTH-1:0]     r_req_data;

    logic [ADDR_SIZE-1:0] w_lk_addr;
    logic                 w_hit;
    logic [WIDTH-1:0]     w_rd_word;
    logic                 w_idle;
    logic                 w_rd_req;
    logic                 w_fill_en;
    logic                 w_upd_en;

    assign w_idle   = (r_state == S_IDLE);
    assign w_rd_req = bus.cpu_read_en && !bus.cpu_write_en;

    // In IDLE the CPU address is looked up; while a store is in flight the latched address is checked instead.
    assign w_lk_addr = w_idle ? bus.cpu_address : r_req_addr;

    assign w_fill_en = (r_state == S_REFILL) && bus.mem_ready;
    assign w_upd_en  = (r_state == S_WRITE) && bus.mem_ready && w_hit;

    dcache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clk          (clk),
        .rst          (rst),
        .i_rd_index   (w_lk_addr[OFFSET_BITS +: INDEX_BITS]),
        .i_rd_tag     (w_lk_addr[ADDR_SIZE-1 -: TAG_BITS]),
        .i_rd_offset  (w_lk_addr[OFFSET_BITS-1:0]),
        .o_hit        (w_hit),
        .o_rd_word    (w_rd_word),
        .i_fill_en    (w_fill_en),
        .i_fill_index (r_req_addr[OFFSET_BITS +: INDEX_BITS]),
        .i_fill_tag   (r_req_addr[ADDR_SIZE-1 -: TAG_BITS]),
        .i_fill_data  (bus.mem_data_in),
        .i_upd_en     (w_upd_en),
        .i_upd_index  (r_req_addr[OFFSET_BITS +: INDEX_BITS]),
        .i_upd_offset (r_req_addr[OFFSET_BITS-1:0]),
        .i_upd_data   (r_req_data)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_write_en)
                    w_next_state = S_WRITE;
                else if (bus.cpu_read_en && !w_hit)
                    w_next_state = S_REFILL;
            end
            S_REFILL, S_WRITE: begin
                if (bus.mem_ready)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_req_addr <= '0;
            r_req_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_idle && bus.cpu_write_en) begin
                r_req_addr <= bus.cpu_address;
                r_req_data <= bus.cpu_data_in;
            end else if (w_idle && bus.cpu_read_en && !w_hit) begin
                r_req_addr <= bus.cpu_address;
            end
        end
    end

    // Memory-side outputs depend only on registered state so they carry no CPU-input paths.
    always_comb begin
        bus.mem_read_en  = 1'b0;
        bus.mem_write_en = 1'b0;
        bus.mem_address  = '0;
        bus.mem_data_out = '0;
        case (r_state)
            S_REFILL: begin
                bus.mem_read_en = 1'b1;
                bus.mem_address = {r_req_addr[ADDR_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            end
            S_WRITE: begin
                bus.mem_write_en = 1'b1;
                bus.mem_address  = r_req_addr;
                bus.mem_data_out = r_req_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.stall        = 1'b0;
        bus.cpu_data_out = '0;
        case (r_state)
            S_IDLE: begin
                bus.stall = bus.cpu_write_en || (bus.cpu_read_en && !w_hit);
                if (w_rd_req && w_hit)
                    bus.cpu_data_out = w_rd_word;
            end
            S_REFILL: begin
                bus.stall = !bus.mem_ready;
                if (bus.mem_ready)
                    bus.cpu_data_out = word_sel(bus.mem_data_in, r_req_addr[OFFSET_BITS-1:0]);
            end
            S_WRITE: begin
                bus.stall = !bus.mem_ready;
            end
            default: ;
        endcase
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (w_idle && w_rd_req) begin
            if (w_hit && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            else if (!w_hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule
